// File: rtl/pc_gen.sv
// pc_gen: fetch program counter with branch/return/jump/stall priority and a return-address stack
module pc_gen #(
  parameter int               WIDTH     = 32,
  parameter int               INC       = 4,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             call,
  input  logic [WIDTH-1:0] link_addr,
  input  logic             ret,
  input  logic [WIDTH-1:0] ret_fallback,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_inc,
  output logic             misalign,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_miss
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int IW = $clog2(INC);
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    ptr_q, ptr_d, top_idx;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             miss_q, miss_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];
  logic             push, pop;
  assign pc          = pc_q;
  assign pc_plus_inc = pc_q + WIDTH'(INC);
  assign ras_empty   = cnt_q == '0;
  assign ras_full    = cnt_q == CW'(RAS_DEPTH);
  assign ras_miss    = miss_q;
  if (IW > 0) begin : g_mis
    assign misalign = |pc_q[IW-1:0];
  end else begin : g_nomis
    assign misalign = 1'b0;
  end
  // next-pc priority select and RAS push/pop bookkeeping; a taken branch squashes ret/call
  always_comb begin
    top_idx = ptr_q - 1'b1;
    push    = !br_taken && !ret && jump && call;
    pop     = !br_taken && ret && !ras_empty;
    miss_d  = !br_taken && ret && ras_empty;
    pc_d    = br_taken ? br_target :
              ret      ? (ras_empty ? ret_fallback : ras_q[top_idx]) :
              jump     ? jump_target :
              stall    ? pc_q : pc_plus_inc;
    ptr_d   = push ? ptr_q + 1'b1 : pop ? ptr_q - 1'b1 : ptr_q;
    cnt_d   = push ? cnt_q + CW'(!ras_full) : pop ? cnt_q - 1'b1 : cnt_q;
    ras_d   = ras_q;
    if (push) ras_d[ptr_q] = link_addr;
  end
  // control state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      ptr_q  <= '0;
      cnt_q  <= '0;
      miss_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      miss_q <= miss_d;
    end
  end
  // stack storage needs no reset; count alone defines validity
  always_ff @(posedge clk) begin
    ras_q <= ras_d;
  end
endmodule
